rx_disparity_monitor: RTL
=========================

# rx_disparity_monitor

Multi-lane running-disparity checker for the receive path, placed after word alignment and alongside the 8b/10b decoder. It tracks running disparity (RD) per lane on incoming 10-bit symbols and flags disparity errors as registered per-lane outputs. It keeps saturating per-lane error counts and raises a per-lane error-rate alarm through a windowed state machine. It checks ones-count and disparity only; code-group validity is the decoder's job.

## Interface
Parameters:
- LANES, 4, number of independent 10-bit lanes
- ERR_CNT_W, 8, width of each per-lane saturating error counter
- WINDOW, 64, valid symbols per error-rate window and clean-run length for alarm exit (≥2)
- ERR_THRESH, 4, errors within one window that raise the alarm (1..WINDOW)

Ports:
- BitCLK_10  in  1  symbol clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- RxValid  in  LANES  per-lane symbol valid
- RxParallel_10  in  10*LANES  lane i symbol on bits [10i+9:10i]
- CntClear  in  1  synchronous clear of all Err_Count fields
- Disparity_Error  out  LANES  one-cycle error flag per checked symbol
- Running_Disp  out  LANES  current RD; 1 = +1, 0 = −1
- Err_Count  out  ERR_CNT_W*LANES  lane i on bits [ERR_CNT_W*(i+1)-1 : ERR_CNT_W*i]
- Err_Alarm  out  LANES  per-lane error-rate alarm

## Operation
- Lanes are fully independent, with no shared state except CntClear.
- Each lane acts only on cycles where RxValid[i]=1. Invalid cycles leave all lane state unchanged and drive Disparity_Error[i]=0 on the next edge.
- Per symbol, let n = ones count and RD = current lane RD:
  - n=5: no error; RD unchanged.
  - n=6: error if RD=+1; RD becomes +1.
  - n=4: error if RD=−1; RD becomes −1.
  - n≤3 or n≥7: always an error; RD unchanged.
- Err_Count[i] increments on each error and saturates at 2^ERR_CNT_W−1.
  - CntClear takes priority: when a clear and an error occur in the same cycle, the result is 0.
- Alarm FSM per lane, states OK and ALARM:
  - OK:
    - win_cnt counts valid symbols 0..WINDOW−1; win_err counts errors in the window.
    - When win_err+error reaches ERR_THRESH, go to ALARM.
    - After the WINDOW-th valid symbol, both counters restart at 0. That symbol's error belongs to the old window.
  - ALARM:
    - clean_cnt counts consecutive error-free valid symbols; any error resets it to 0.
    - At WINDOW clean symbols, go to OK with win_cnt, win_err and clean_cnt all 0.
- CntClear does not affect RD, the FSM or the window counters.

## Timing
- Latency is 1 cycle. A symbol sampled at edge k drives Disparity_Error, Running_Disp, Err_Count and Err_Alarm updates visible after edge k.
- Err_Alarm rises in the same cycle as the Disparity_Error pulse that reaches ERR_THRESH.
- Err_Alarm falls in the cycle after the WINDOW-th clean symbol is sampled.
- Reset asserted at any time, including mid-window or in ALARM:
  - Disparity_Error=0, Running_Disp=0 (RD −1), Err_Count=0, Err_Alarm=0.
  - FSM goes to OK and all window counters go to 0, immediately and asynchronously.
  - The first valid symbol after deassertion is checked against RD −1.
- Back-to-back valid symbols are accepted every cycle with no stall.

## Configuration
- RX_DISP_ERR_CNT_EN:
  - Defined: the Err_Count counters and CntClear logic are built as above.
  - Undefined: the counters are not built, Err_Count is tied to 0 and CntClear is ignored. Disparity_Error, Running_Disp and Err_Alarm behaviour is unchanged.

## Test plan
- Reset, then lane 0 sends 10'h3F0, 10'h3F0:
  - The first symbol gives no error, with Running_Disp[0]=1.
  - The second gives Disparity_Error[0]=1 for one cycle, Err_Count lane0=1, Running_Disp[0] still 1.
  - Other lanes are idle with no change.
- Lane 1 alternates 10'h3F0 / 10'h0F0 / 10'h1F0 for 300 symbols with RxValid toggling randomly: zero errors, and RD toggles only on 6- and 4-ones symbols.
- Lane 2 receives 10'h3FF then 10'h000: two error pulses, RD stays −1, Err_Count lane2=2.
- With WINDOW=16 and ERR_THRESH=4, lane 3 receives 4 errors within 16 symbols:
  - Err_Alarm[3] rises together with the 4th pulse.
  - After 15 clean symbols it is still high; after the 16th clean symbol it drops.
  - One error at clean symbol 10 restarts the count.
- With ERR_CNT_W=4, send 20 errors: Err_Count=15. Then CntClear coincident with an error gives 0. With RX_DISP_ERR_CNT_EN undefined, the count stays 0 throughout.
- Assert Reset asynchronously mid-symbol while lane 0 is at RD +1 and in ALARM:
  - All outputs go to 0 before the next edge.
  - After release, 10'h0F0 flags an error, because RD is back at −1.

Source files
------------

// File: rtl/rx_disparity_monitor.sv
// ============================================================================
// Module  : rx_disparity_monitor
// Brief   : Per-lane 10-bit running-disparity checker with error counters and
//           windowed error-rate alarm. Optional counters: RX_DISP_ERR_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_disparity_monitor #(
    parameter int LANES      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 4
) (
    input  logic                       BitCLK_10,
    input  logic                       Reset,
    input  logic [LANES-1:0]           RxValid,
    input  logic [10*LANES-1:0]        RxParallel_10,
    input  logic                       CntClear,
    output logic [LANES-1:0]           Disparity_Error,
    output logic [LANES-1:0]           Running_Disp,
    output logic [ERR_CNT_W*LANES-1:0] Err_Count,
    output logic [LANES-1:0]           Err_Alarm
);

    localparam int             CW       = $clog2(WINDOW + 1);
    localparam logic [CW-1:0]  WIN_LAST = CW'(WINDOW - 1);
    localparam logic [CW-1:0]  THRESH_V = CW'(ERR_THRESH);
    localparam logic [0:0]     ST_OK    = 1'b0;
    localparam logic [0:0]     ST_ALARM = 1'b1;

    function automatic logic [3:0] ones10(input logic [9:0] s);
        logic [3:0] n;
        n = 4'd0;
        for (int b = 0; b < 10; b++) n = n + {3'd0, s[b]};
        return n;
    endfunction

`ifndef RX_DISP_ERR_CNT_EN
    logic unused_clear;
    assign unused_clear = CntClear;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [9:0]    sym;
        logic [3:0]    n;
        logic          err, err_v, rd_nxt;
        logic          rd, de;
        logic [0:0]    state, state_nxt;
        logic [CW-1:0] win_cnt, win_cnt_nxt, win_err, win_err_nxt;
        logic [CW-1:0] clean_cnt, clean_cnt_nxt;

        assign sym = RxParallel_10[10*i +: 10];

        always_comb begin
            n      = ones10(sym);
            err    = 1'b0;
            rd_nxt = rd;
            case (n)
                4'd5:    err = 1'b0;
                4'd6:    begin err = rd;  rd_nxt = 1'b1; end
                4'd4:    begin err = ~rd; rd_nxt = 1'b0; end
                default: err = 1'b1;
            endcase
            err_v = RxValid[i] & err;
        end

        always_ff @(posedge BitCLK_10 or negedge Reset) begin
            if (!Reset) begin
                rd <= 1'b0;
                de <= 1'b0;
            end else begin
                de <= err_v;
                if (RxValid[i]) rd <= rd_nxt;
            end
        end

        // Alarm FSM: state register
        always_ff @(posedge BitCLK_10 or negedge Reset) begin
            if (!Reset) begin
                state     <= ST_OK;
                win_cnt   <= '0;
                win_err   <= '0;
                clean_cnt <= '0;
            end else begin
                state     <= state_nxt;
                win_cnt   <= win_cnt_nxt;
                win_err   <= win_err_nxt;
                clean_cnt <= clean_cnt_nxt;
            end
        end

        // Alarm FSM: next state; the last symbol of a window still counts in it
        always_comb begin
            state_nxt     = state;
            win_cnt_nxt   = win_cnt;
            win_err_nxt   = win_err;
            clean_cnt_nxt = clean_cnt;
            if (RxValid[i]) begin
                case (state)
                    ST_OK: begin
                        if (win_err + CW'(err) == THRESH_V) begin
                            state_nxt     = ST_ALARM;
                            win_cnt_nxt   = '0;
                            win_err_nxt   = '0;
                            clean_cnt_nxt = '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt_nxt = '0;
                            win_err_nxt = '0;
                        end else begin
                            win_cnt_nxt = win_cnt + CW'(1);
                            win_err_nxt = win_err + CW'(err);
                        end
                    end
                    ST_ALARM: begin
                        if (err) begin
                            clean_cnt_nxt = '0;
                        end else if (clean_cnt == WIN_LAST) begin
                            state_nxt     = ST_OK;
                            win_cnt_nxt   = '0;
                            win_err_nxt   = '0;
                            clean_cnt_nxt = '0;
                        end else begin
                            clean_cnt_nxt = clean_cnt + CW'(1);
                        end
                    end
                    default: state_nxt = ST_OK;
                endcase
            end
        end

        // Alarm FSM: output
        always_comb begin
            Err_Alarm[i] = (state == ST_ALARM);
        end

        assign Disparity_Error[i] = de;
        assign Running_Disp[i]    = rd;

`ifdef RX_DISP_ERR_CNT_EN
        logic [ERR_CNT_W-1:0] cnt;
        always_ff @(posedge BitCLK_10 or negedge Reset) begin
            if (!Reset)                   cnt <= '0;
            else if (CntClear)            cnt <= '0;
            else if (err_v && cnt != '1)  cnt <= cnt + ERR_CNT_W'(1);
        end
        assign Err_Count[ERR_CNT_W*i +: ERR_CNT_W] = cnt;
`else
        assign Err_Count[ERR_CNT_W*i +: ERR_CNT_W] = '0;
`endif
    end

endmodule

`default_nettype wire
